// File: rtl/sample_pkg.sv
// Shared sample-record definitions, also used by the sample multiplexer.
// Describes the 48-bit timetag record carried as 6 bytes, MSB byte first.
package sample_pkg;

    localparam int SAMPLE_BYTES = 6;
    localparam int SAMPLE_W     = 8 * SAMPLE_BYTES;
    localparam int BYTE_IDX_W   = 3;

    typedef logic [SAMPLE_W-1:0]   sample_t;
    typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

    // Last byte position of a record with the given number of bytes.
    function automatic byte_idx_t last_byte_idx(input int bytes_per_sample);
        return byte_idx_t'(bytes_per_sample - 1);
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// Idle-gap watchdog for a partially received record.
// Counts idle cycles while enabled and pulses expire on the cycle the
// count reaches TIMEOUT_CYCLES-1. The counter restarts on clear or expiry.
// Only instantiated when SAMPLE_DEMUX_TIMEOUT_EN is defined.
module byte_timeout
    import sample_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expire = count_en & (cnt_q == CNT_LAST);

    // Idle counter: restarts on clear or expiry, advances while enabled.
    always_ff @(posedge clk) begin
        if (reset || clear || expire) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sample_demultiplexer.sv
// Reassembles sample records from a byte stream (MSB byte first).
// One record assembles while the previous one waits in the output register;
// the byte source is stalled only when both are full.
// Optional idle timeout on partial records: define SAMPLE_DEMUX_TIMEOUT_EN.
module sample_demultiplexer
    import sample_pkg::*;
#(
    parameter int BYTES_PER_SAMPLE = SAMPLE_BYTES,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data,
    input  logic                          data_rdy,
    output logic                          data_ack,
    output logic [8*BYTES_PER_SAMPLE-1:0] sample,
    output logic                          sample_rdy,
    input  logic                          sample_ack,
    output logic                          frame_err,
    output logic [BYTE_IDX_W-1:0]         byte_idx
);

    localparam int        SW       = 8 * BYTES_PER_SAMPLE;
    localparam byte_idx_t LAST_IDX = last_byte_idx(BYTES_PER_SAMPLE);

    logic [SW-1:0] asm_q, asm_d;
    logic [SW-1:0] out_q, out_d;
    byte_idx_t     idx_q, idx_d;
    logic          full_q, full_d;
    logic          rdy_q, rdy_d;

    logic [SW-1:0] asm_shift;
    logic          xfer;
    logic          ack_seen;
    logic          out_free;
    logic          last_byte;
    logic          expire;

    // A complete record parked in the assembly register blocks new bytes.
    assign data_ack  = data_rdy & ~full_q & ~reset;
    assign xfer      = data_ack;
    assign ack_seen  = rdy_q & sample_ack;
    assign out_free  = ~rdy_q | sample_ack;
    assign last_byte = (idx_q == LAST_IDX);
    assign asm_shift = {asm_q[SW-9:0], data};

    // Next-state: output hand-off, byte shift-in, record completion, timeout.
    always_comb begin
        asm_d  = asm_q;
        idx_d  = idx_q;
        full_d = full_q;
        out_d  = out_q;
        rdy_d  = rdy_q;

        if (ack_seen) begin
            rdy_d = 1'b0;
        end

        // Parked record moves out the same cycle the sink takes the old one.
        if (full_q && ack_seen) begin
            out_d  = asm_q;
            rdy_d  = 1'b1;
            full_d = 1'b0;
        end

        if (xfer) begin
            asm_d = asm_shift;
            if (last_byte) begin
                idx_d = '0;
                if (out_free) begin
                    out_d = asm_shift;
                    rdy_d = 1'b1;
                end else begin
                    full_d = 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (expire) begin
            // Only partial records can expire; a parked record has idx 0.
            asm_d = '0;
            idx_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q  <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
            out_q  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            idx_q  <= idx_d;
            full_q <= full_d;
            out_q  <= out_d;
            rdy_q  <= rdy_d;
        end
    end

    assign sample     = out_q;
    assign sample_rdy = rdy_q;
    assign byte_idx   = idx_q;

`ifdef SAMPLE_DEMUX_TIMEOUT_EN
    logic count_en;
    logic cnt_clear;
    logic frame_err_q;

    assign count_en  = (idx_q != '0) & ~xfer;
    assign cnt_clear = xfer | (idx_q == '0);

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .count_en(count_en),
        .clear   (cnt_clear),
        .expire  (expire)
    );

    // One-cycle error pulse following the discard of a partial record.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= expire & ~xfer;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign expire    = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_sample_demultiplexer.sv
// Bench for sample_demultiplexer: directed scenarios plus randomized
// byte/ack gaps, checked every cycle against a queue-based record model
// and an in-order record scoreboard.
`timescale 1ns/1ps
module tb_sample_demultiplexer;

    localparam int NB = 6;
    localparam int SW = 48;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    data;
    logic          data_rdy;
    logic          data_ack;
    logic [SW-1:0] sample;
    logic          sample_rdy;
    logic          sample_ack;
    logic          frame_err;
    logic [2:0]    byte_idx;

    sample_demultiplexer #(
        .BYTES_PER_SAMPLE(NB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .data_rdy  (data_rdy),
        .data_ack  (data_ack),
        .sample    (sample),
        .sample_rdy(sample_rdy),
        .sample_ack(sample_ack),
        .frame_err (frame_err),
        .byte_idx  (byte_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus state
    logic [7:0]    tx_q[$];
    logic [SW-1:0] exp_recs[$];
    int            rdy_pct = 100;
    int            ack_pct = 100;
    int            max_gap = 1000;
    int            gap = 0;
    bit            rdy_force = 1'b0;
    bit            took = 1'b0;

    // observation state
    int            cyc = 0;
    int            last_xfer_cyc = 0;
    int            last_rise_lat = -1;
    bit            prev_rdy = 1'b0;
    int            ferr_cnt = 0;
    int            recs_done = 0;
    logic [SW-1:0] last_rec = '0;

    // reference model: bytes of the partial record, a parked record, the output
    logic [7:0]    m_part[$];
    bit            m_pend_v = 1'b0;
    logic [SW-1:0] m_pend = '0;
    bit            m_out_v = 1'b0;
    logic [SW-1:0] m_out = '0;
    bit            m_ferr = 1'b0;
    int            m_idle = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // byte source: holds a presented byte until it is taken
    always begin
        @(posedge clk);
        #2;
        if (data_rdy && took && tx_q.size() > 0) void'(tx_q.pop_front());
        if (rdy_force) begin
            data_rdy = 1'b1;
            data     = 8'h5A;
        end else if (data_rdy && !took && tx_q.size() > 0) begin
            data = tx_q[0];
        end else if (tx_q.size() > 0 &&
                     (gap >= max_gap || $urandom_range(99) < rdy_pct)) begin
            data_rdy = 1'b1;
            data     = tx_q[0];
            gap      = 0;
        end else begin
            data_rdy = 1'b0;
            data     = 8'($urandom);
            gap++;
        end
        sample_ack = ($urandom_range(99) < ack_pct);
    end

    // per-cycle compare against the model, scoreboard, then model update
    always @(negedge clk) begin
        logic          exp_ack;
        logic          ack_hit;
        logic          out_free;
        logic [SW-1:0] rec;
        cyc++;
        exp_ack = data_rdy & !reset & !m_pend_v;
        chk("data_ack", 64'(data_ack), 64'(exp_ack));
        chk("sample_rdy", 64'(sample_rdy), 64'(m_out_v));
        if (m_out_v) chk("sample", 64'(sample), 64'(m_out));
        chk("byte_idx", 64'(byte_idx), 64'(m_part.size()));
        chk("frame_err", 64'(frame_err), 64'(m_ferr));

        if (sample_rdy && !prev_rdy) last_rise_lat = cyc - last_xfer_cyc;
        prev_rdy = sample_rdy;
        took = data_rdy & data_ack;
        if (took) last_xfer_cyc = cyc;
        if (frame_err) ferr_cnt++;

        if (sample_rdy && sample_ack && !reset) begin
            if (exp_recs.size() == 0) begin
                chk("scoreboard_extra", 64'(sample), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                rec = exp_recs.pop_front();
                chk("scoreboard", 64'(sample), 64'(rec));
                last_rec = sample;
                recs_done++;
                $display("rec %0d sample %012h", recs_done, sample);
            end
        end

        ack_hit  = sample_ack & m_out_v;
        out_free = !m_out_v || ack_hit;
        if (reset) begin
            m_part.delete();
            m_pend_v = 1'b0;
            m_out_v  = 1'b0;
            m_ferr   = 1'b0;
            m_idle   = 0;
        end else begin
            m_ferr = 1'b0;
            if (ack_hit) begin
                if (m_pend_v) begin
                    m_out    = m_pend;
                    m_pend_v = 1'b0;
                end else begin
                    m_out_v = 1'b0;
                end
            end
            if (exp_ack) begin
                m_part.push_back(data);
                m_idle = 0;
                if (m_part.size() == NB) begin
                    rec = '0;
                    foreach (m_part[k]) rec = (rec << 8) | SW'(m_part[k]);
                    m_part.delete();
                    if (out_free) begin
                        m_out   = rec;
                        m_out_v = 1'b1;
                    end else begin
                        m_pend   = rec;
                        m_pend_v = 1'b1;
                    end
                end
            end else if (m_part.size() != 0) begin
`ifdef SAMPLE_DEMUX_TIMEOUT_EN
                if (m_idle == TO - 1) begin
                    m_part.delete();
                    m_ferr = 1'b1;
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
`endif
            end else begin
                m_idle = 0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rec(input logic [SW-1:0] rec, input bit score);
        for (int i = NB - 1; i >= 0; i--) tx_q.push_back(rec[8*i +: 8]);
        if (score) exp_recs.push_back(rec);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_recs.size() != 0 || tx_q.size() != 0 || sample_rdy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", 64'(exp_recs.size() + tx_q.size()), 64'd0);
    endtask

    task automatic wait_idx(input int idx, input int budget);
        int n = 0;
        while (byte_idx != 3'(idx) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_byte_idx", 64'(byte_idx), 64'(idx));
    endtask

    initial begin
        int n;
        int ferr_base;
        reset      = 1'b1;
        rdy_force  = 1'b1;
        data_rdy   = 1'b0;
        data       = 8'h00;
        sample_ack = 1'b0;
        tick(3);
        // reset state, with data_rdy forced high
        chk("rst_data_ack", 64'(data_ack), 64'd0);
        chk("rst_sample_rdy", 64'(sample_rdy), 64'd0);
        chk("rst_sample", 64'(sample), 64'd0);
        chk("rst_byte_idx", 64'(byte_idx), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        reset     = 1'b0;
        rdy_force = 1'b0;
        tick(2);

        // 1: single record, sink always ready
        send_rec(48'h010203040506, 1'b1);
        n = 0;
        while (!sample_rdy && n < 40) begin
            tick();
            n++;
        end
        chk("t1_sample_rdy", 64'(sample_rdy), 64'd1);
        chk("t1_sample", 64'(sample), 64'h010203040506);
        tick();
        chk("t1_latency", 64'(last_rise_lat), 64'd1);
        chk("t1_rdy_one_cycle", 64'(sample_rdy), 64'd0);
        chk("t1_last_rec", 64'(last_rec), 64'h010203040506);
        drain(50);

        // 2: back-to-back records with a stalled sink
        ack_pct = 0;
        send_rec(48'h010203040506, 1'b1);
        send_rec(48'h0708090A0B0C, 1'b1);
        send_rec(48'h0D0E0F101112, 1'b1);
        tick(30);
        chk("t2_sample_rdy", 64'(sample_rdy), 64'd1);
        chk("t2_first_held", 64'(sample), 64'h010203040506);
        chk("t2_stall_ack", 64'(data_ack), 64'd0);
        chk("t2_stall_idx", 64'(byte_idx), 64'd0);
        ack_pct = 100;
        tick();
        ack_pct = 0;
        tick(2);
        chk("t2_second_out", 64'(sample), 64'h0708090A0B0C);
        tick(12);
        chk("t2_stream_resumed", 64'(tx_q.size()), 64'd0);
        ack_pct = 100;
        drain(100);
        chk("t2_last_rec", 64'(last_rec), 64'h0D0E0F101112);

        // 3: reset mid-record
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        tx_q.push_back(8'h33);
        wait_idx(3, 40);
        reset     = 1'b1;
        rdy_force = 1'b1;
        tick(2);
        chk("t3_rst_data_ack", 64'(data_ack), 64'd0);
        chk("t3_rst_sample_rdy", 64'(sample_rdy), 64'd0);
        chk("t3_rst_byte_idx", 64'(byte_idx), 64'd0);
        reset     = 1'b0;
        rdy_force = 1'b0;
        tick();
        send_rec(48'hAABBCCDDEEFF, 1'b1);
        drain(100);
        chk("t3_last_rec", 64'(last_rec), 64'hAABBCCDDEEFF);

`ifdef SAMPLE_DEMUX_TIMEOUT_EN
        // 4: partial record times out
        ferr_base = ferr_cnt;
        tx_q.push_back(8'h51);
        tx_q.push_back(8'h52);
        wait_idx(2, 40);
        tick(20);
        chk("t4_frame_err_pulses", 64'(ferr_cnt - ferr_base), 64'd1);
        chk("t4_byte_idx", 64'(byte_idx), 64'd0);
        send_rec(48'h616263646566, 1'b1);
        drain(100);
        chk("t4_clean_rec", 64'(last_rec), 64'h616263646566);

        // 5: byte lands on the expiry cycle
        ferr_base = ferr_cnt;
        tx_q.push_back(8'h71);
        tx_q.push_back(8'h72);
        wait_idx(2, 40);
        n = 0;
        while (m_idle != TO - 1 && n < 20) begin
            tick();
            n++;
        end
        chk("t5_reach_expiry", 64'(m_idle), 64'(TO - 1));
        tx_q.push_back(8'h73);
        tick(3);
        chk("t5_no_frame_err", 64'(ferr_cnt - ferr_base), 64'd0);
        chk("t5_byte_idx", 64'(byte_idx), 64'd3);
        tx_q.push_back(8'h74);
        tx_q.push_back(8'h75);
        tx_q.push_back(8'h76);
        exp_recs.push_back(48'h717273747576);
        drain(100);
        chk("t5_rec", 64'(last_rec), 64'h717273747576);
`else
        ferr_base = 0;
`endif

        // 6: random gaps on both sides, 1000 records
        n = recs_done;
        rdy_pct = 70;
        ack_pct = 60;
        max_gap = 4;
        for (int r = 0; r < 1000; r++) send_rec({$urandom, 16'($urandom)}, 1'b1);
        drain(40000);
        chk("t6_records", 64'(recs_done - n), 64'd1000);
        chk("t6_frame_err", 64'(ferr_cnt - ferr_base), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
